// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the restoring divider family.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 2;

  // All-ones quotient reported on divide-by-zero or overflow, for a w-bit quotient.
  // Callers slice the low w bits.
  function automatic logic [63:0] err_quotient(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One radix-2 restoring step: shift in one dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] t;

  // Compare on WIDTH+1 bits; since rem < divisor, t - divisor always fits in WIDTH bits.
  always_comb begin
    t       = {rem, next_bit};
    q_bit   = (t >= {1'b0, divisor});
    new_rem = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned     CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [63:0]     ERR_Q_WIDE = err_quotient(WIDTH);
  localparam logic [WIDTH-1:0] ERR_Q     = ERR_Q_WIDE[WIDTH-1:0];

  div_state_t       state_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] qacc_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] dvd_hi;
  logic [WIDTH-1:0] dvd_lo;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] qacc_d;

  assign dvd_hi = dividend[2*WIDTH-1:WIDTH];
  assign dvd_lo = dividend[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .next_bit (shreg_q[WIDTH-1]),
    .divisor  (divisor_q),
    .new_rem  (rem_d),
    .q_bit    (qbit_d)
  );

  // Quotient accumulator with the new bit shifted in at the LSB.
  always_comb begin
    qacc_d = (qacc_q << 1) | WIDTH'(qbit_d);
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      qacc_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            divisor_q  <= divisor;
            rem_q      <= dvd_hi;
            shreg_q    <= dvd_lo;
            qacc_q     <= '0;
            cnt_q      <= CNT_LAST;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              dbz_q       <= 1'b1;
              quotient_q  <= ERR_Q;
              remainder_q <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (dvd_hi >= divisor) begin
              ovf_q       <= 1'b1;
              quotient_q  <= ERR_Q;
              remainder_q <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          shreg_q <= shreg_q << 1;
          qacc_q  <= qacc_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= qacc_d;
            remainder_q <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
